// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: data word, RAM handshake state, arbiter FSM state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM handshake reported by the memory model / controller
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter ownership state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter for the single-ported main RAM
//
// Purpose: grants the RAM to either the fetch stream (i*) or the data stream
// (d*) for one full access at a time. Data wins by default. Build option
// MEM_ARB_FAIR_EN adds a 4-bit starvation counter so that after STARVE_MAX
// consecutive data completions with fetch waiting, fetch wins the next
// arbitration.
//
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   iREN, iaddr -> iwait, iload          instruction read request / response
//   dREN, dWEN, daddr, dstore -> dwait, dload   data request / response
//   ramREN, ramWEN, ramaddr, ramstore    RAM request strobes and operands
//   ramload, ramstate                    RAM read data and handshake state
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  arb_state_t state_q, state_d;
  logic       dreq;
  logic       pick_fetch;
  logic       d_done;

  assign dreq = dREN | dWEN;

`ifdef MEM_ARB_FAIR_EN
  logic [3:0] starve_q, starve_d;

  // Fetch wins when idle-side data is absent, or when it has been starved long enough
  assign pick_fetch = iREN & (~dreq | (starve_q == 4'(STARVE_MAX)));

  always_comb begin
    starve_d = starve_q;
    if (!iREN) begin
      starve_d = '0;
    end else if (state_q == IDLE && state_d == IGNT) begin
      starve_d = '0;
    end else if (d_done && starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end
`else
  assign pick_fetch = iREN & ~dreq;
`endif

  always_comb begin
    state_d  = state_q;
    d_done   = 1'b0;
    // A pending request always sees wait high unless its access completes now
    iwait    = iREN;
    dwait    = dreq;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_fetch)  state_d = IGNT;
        else if (dreq)   state_d = DGNT;
      end

      IGNT: begin
        if (!iREN) begin
          // Fetch withdrawn (flush): strobes drop now, nothing returned
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end
        end
      end

      DGNT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          // FREE/BUSY/ERROR all hold the grant; ERROR is simply retried
          if (ramstate == ACCESS) begin
            dwait   = 1'b0;
            dload   = dREN ? ramload : '0;
            d_done  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
`ifdef MEM_ARB_FAIR_EN
      starve_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_ARB_FAIR_EN
      starve_q <= starve_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 2;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;
  ramstate_t ramstate;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_inputs;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
  endtask

  task automatic test_reset;
    idle_inputs();
    nRST = 0;
    tick(); tick();
    #1;
    n_checks++; if (ramREN !== 1'b0)   begin n_fail++; $display("FAIL reset_ramREN got %0h want 0", ramREN); end
    n_checks++; if (ramWEN !== 1'b0)   begin n_fail++; $display("FAIL reset_ramWEN got %0h want 0", ramWEN); end
    n_checks++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL reset_ramaddr got %h want 0", ramaddr); end
    n_checks++; if (ramstore !== 32'h0) begin n_fail++; $display("FAIL reset_ramstore got %h want 0", ramstore); end
    n_checks++; if (iwait !== 1'b0 || dwait !== 1'b0) begin n_fail++; $display("FAIL reset_waits got %b%b want 00", iwait, dwait); end
    n_checks++; if (iload !== 32'h0 || dload !== 32'h0) begin n_fail++; $display("FAIL reset_loads got %h %h want 0 0", iload, dload); end
    nRST = 1;
    iREN = 1; dREN = 1;
    #1;
    n_checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL reset_wait_rise got %b%b want 11", iwait, dwait); end
    idle_inputs();
    tick();
  endtask

  task automatic test_lone_fetch;
    iREN = 1; iaddr = 32'h40;
    #1;
    n_checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL fetch_c0 got iwait=%b ramREN=%b want 1 0", iwait, ramREN); end
    tick();
    ramstate = BUSY; #1;
    n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin n_fail++; $display("FAIL fetch_c1 got ramREN=%b addr=%h iwait=%b want 1 40 1", ramREN, ramaddr, iwait); end
    tick();
    #1;
    n_checks++; if (iwait !== 1'b1 || ramREN !== 1'b1) begin n_fail++; $display("FAIL fetch_c2 got iwait=%b ramREN=%b want 1 1", iwait, ramREN); end
    tick();
    ramstate = ACCESS; ramload = 32'h8C010004; #1;
    n_checks++; if (iwait !== 1'b0 || iload !== 32'h8C010004) begin n_fail++; $display("FAIL fetch_c3 got iwait=%b iload=%h want 0 8c010004", iwait, iload); end
    tick();
    iREN = 0; ramstate = FREE; #1;
    n_checks++; if (ramREN !== 1'b0 || iload !== 32'h0) begin n_fail++; $display("FAIL fetch_c4 got ramREN=%b iload=%h want 0 0", ramREN, iload); end
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous;
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    tick();
    ramstate = BUSY; #1;
    n_checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL simul_dgnt got wen=%b ren=%b addr=%h store=%h want 1 0 80 deadbeef", ramWEN, ramREN, ramaddr, ramstore); end
    n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL simul_iwait_held got %b want 1", iwait); end
    tick();
    ramstate = ACCESS; #1;
    n_checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL simul_dcomplete got dwait=%b iwait=%b want 0 1", dwait, iwait); end
    tick();
    dWEN = 0; ramstate = FREE; #1;
    n_checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL simul_idle got ren=%b wen=%b iwait=%b want 0 0 1", ramREN, ramWEN, iwait); end
    tick();
    ramstate = ACCESS; ramload = 32'h0BADF00D; #1;
    n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || iwait !== 1'b0 || iload !== 32'h0BADF00D)
      begin n_fail++; $display("FAIL simul_ignt got ren=%b addr=%h iwait=%b iload=%h want 1 44 0 0badf00d", ramREN, ramaddr, iwait, iload); end
    idle_inputs();
    tick();
  endtask

  task automatic test_error_retry;
    dREN = 1; daddr = 32'h100;
    tick();
    for (int k = 0; k < 3; k++) begin
      ramstate = ERROR; #1;
      n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 1'b1)
        begin n_fail++; $display("FAIL retry_err%0d got ren=%b addr=%h dwait=%b want 1 100 1", k, ramREN, ramaddr, dwait); end
      tick();
    end
    ramstate = ACCESS; ramload = 32'hCAFE0001; #1;
    n_checks++; if (dwait !== 1'b0 || dload !== 32'hCAFE0001 || ramREN !== 1'b1)
      begin n_fail++; $display("FAIL retry_access got dwait=%b dload=%h ren=%b want 0 cafe0001 1", dwait, dload, ramREN); end
    idle_inputs();
    tick();
  endtask

  task automatic test_abort;
    dREN = 1; daddr = 32'h120; ramstate = BUSY;
    tick();
    #1;
    n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL abort_granted got ren=%b want 1", ramREN); end
    tick();
    dREN = 0; #1;
    n_checks++; if (ramREN !== 1'b0 || dwait !== 1'b0 || dload !== 32'h0)
      begin n_fail++; $display("FAIL abort_drop got ren=%b dwait=%b dload=%h want 0 0 0", ramREN, dwait, dload); end
    tick();
    dREN = 1; #1;
    n_checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin n_fail++; $display("FAIL abort_idle got ren=%b dwait=%b want 0 1", ramREN, dwait); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_write;
    dWEN = 1; daddr = 32'h140; dstore = 32'h12345678; ramstate = BUSY;
    tick();
    #1;
    n_checks++; if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL rstw_granted got wen=%b want 1", ramWEN); end
    nRST = 0;
    tick();
    nRST = 1; #1;
    n_checks++; if (ramWEN !== 1'b0 || ramstore !== 32'h0 || dwait !== 1'b1)
      begin n_fail++; $display("FAIL rstw_after got wen=%b store=%h dwait=%b want 0 0 1", ramWEN, ramstore, dwait); end
    idle_inputs();
    tick();
  endtask

  task automatic test_fairness;
    byte exp_g[6];
    byte got_g[$];
`ifdef MEM_ARB_FAIR_EN
    exp_g = '{"D", "D", "I", "D", "D", "I"};
`else
    exp_g = '{"D", "D", "D", "D", "D", "D"};
`endif
    iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h200; ramstate = ACCESS; ramload = 32'h5A5A5A5A;
    for (int c = 0; c < 40 && got_g.size() < 6; c++) begin
      #1;
      if (ramREN === 1'b1) got_g.push_back((ramaddr === 32'h300) ? "I" : "D");
      tick();
    end
    n_checks++; if (got_g.size() != 6) begin n_fail++; $display("FAIL fair_count got %0d grants want 6", got_g.size()); end
    for (int k = 0; k < 6; k++) begin
      byte g;
      g = (k < got_g.size()) ? got_g[k] : "?";
      n_checks++; if (g != exp_g[k]) begin n_fail++; $display("FAIL fair_grant%0d got %c want %c", k, g, exp_g[k]); end
    end
    idle_inputs();
    tick(); tick();
  endtask

  // Transaction-level model: who owns the RAM and how many data accesses
  // have completed in a row while fetch was waiting.
  task automatic test_random;
    int owner;   // 0 none, 1 fetch, 2 data
    int streak;
    logic  e_iwait, e_dwait, e_ren, e_wen;
    word_t e_iload, e_dload, e_addr, e_store;
    logic  dreq, done, want_i;
    nRST = 0; idle_inputs(); tick(); nRST = 1;
    owner = 0; streak = 0;
    for (int c = 0; c < 600; c++) begin
      int dk;
      nRST  = ($urandom_range(0, 29) != 0);
      iREN  = ($urandom_range(0, 3) != 0);
      dk    = int'($urandom_range(0, 3));
      dREN  = (dk == 1 || dk == 3);
      dWEN  = (dk == 2);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      #1;
      dreq = dREN | dWEN;
      e_iwait = iREN; e_dwait = dreq; e_iload = 0; e_dload = 0;
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; done = 0;
      if (owner == 1 && iREN) begin
        e_ren = 1; e_addr = iaddr;
        if (ramstate == ACCESS) begin e_iwait = 0; e_iload = ramload; done = 1; end
      end else if (owner == 2 && dreq) begin
        e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore;
        if (ramstate == ACCESS) begin e_dwait = 0; e_dload = dREN ? ramload : 0; done = 1; end
      end
      n_checks++;
      if ({iwait, dwait, ramREN, ramWEN} !== {e_iwait, e_dwait, e_ren, e_wen})
        begin n_fail++; $display("FAIL rand_ctl c=%0d got iw/dw/ren/wen=%b want %b", c, {iwait, dwait, ramREN, ramWEN}, {e_iwait, e_dwait, e_ren, e_wen}); end
      n_checks++;
      if (ramaddr !== e_addr || ramstore !== e_store)
        begin n_fail++; $display("FAIL rand_ram c=%0d got addr=%h store=%h want %h %h", c, ramaddr, ramstore, e_addr, e_store); end
      n_checks++;
      if (iload !== e_iload || dload !== e_dload)
        begin n_fail++; $display("FAIL rand_load c=%0d got i=%h d=%h want %h %h", c, iload, dload, e_iload, e_dload); end
`ifdef MEM_ARB_FAIR_EN
      want_i = iREN && (!dreq || streak == SMAX);
`else
      want_i = iREN && !dreq;
`endif
      if (!nRST) begin
        owner = 0; streak = 0;
      end else begin
        if (!iREN) streak = 0;
        else if (owner == 0 && want_i) streak = 0;
        else if (owner == 2 && done && streak < 15) streak++;
        if (owner == 0) owner = want_i ? 1 : (dreq ? 2 : 0);
        else if (owner == 1 && (!iREN || done)) owner = 0;
        else if (owner == 2 && (!dreq || done)) owner = 0;
      end
      tick();
    end
    nRST = 1;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_error_retry();
    test_abort();
    test_reset_mid_write();
    test_fairness();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
